sc_matrix_tx: RTL and testbench

SC_MATRIX_TX -- requirements
Module: SC_MATRIX_TX

---
 rtl/sc_matrix_tx.sv | 108 ++++++++++
 tb/tb_sc_matrix_tx.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/sc_matrix_tx.sv
// sc_matrix_tx: serial refresher for a MAX7219-type 8x8 LED matrix driver.
// Sends five init words once, then the eight row words per frame.
module sc_matrix_tx #(
    parameter int DATAWIDTH_BUS = 8,
    parameter int CLKDIV = 4,
    parameter logic [3:0] INTENSITY = 4'hF
) (
    input  logic                     SC_MATRIX_TX_CLOCK_50,
    input  logic                     SC_MATRIX_TX_RESET,
    input  logic [DATAWIDTH_BUS-1:0] SC_MATRIX_TX_ROW0_IN,
    input  logic [DATAWIDTH_BUS-1:0] SC_MATRIX_TX_ROW1_IN,
    input  logic [DATAWIDTH_BUS-1:0] SC_MATRIX_TX_ROW2_IN,
    input  logic [DATAWIDTH_BUS-1:0] SC_MATRIX_TX_ROW3_IN,
    input  logic [DATAWIDTH_BUS-1:0] SC_MATRIX_TX_ROW4_IN,
    input  logic [DATAWIDTH_BUS-1:0] SC_MATRIX_TX_ROW5_IN,
    input  logic [DATAWIDTH_BUS-1:0] SC_MATRIX_TX_ROW6_IN,
    input  logic [DATAWIDTH_BUS-1:0] SC_MATRIX_TX_ROW7_IN,
    input  logic                     SC_MATRIX_TX_EN_IN,
    output logic                     SC_MATRIX_TX_DIN_OUT,
    output logic                     SC_MATRIX_TX_CLK_OUT,
    output logic                     SC_MATRIX_TX_LOAD_OUT,
    output logic                     SC_MATRIX_TX_BUSY_OUT,
    output logic                     SC_MATRIX_TX_FRAME_DONE_OUT
);
    typedef enum logic [2:0] {IDLE, LOAD_WORD, SHIFT_LOW, SHIFT_HIGH, LATCH, NEXT} state_t;
    state_t state, state_n;
    logic [3:0] idx, bit_cnt;
    logic [7:0] half_cnt;
    logic [15:0] sreg, word;
    logic init_done, half_end;
    logic [2:0] k;
    logic [7:0] rows [8];
    logic [7:0] snap [8];

    assign rows[0] = 8'(SC_MATRIX_TX_ROW0_IN);
    assign rows[1] = 8'(SC_MATRIX_TX_ROW1_IN);
    assign rows[2] = 8'(SC_MATRIX_TX_ROW2_IN);
    assign rows[3] = 8'(SC_MATRIX_TX_ROW3_IN);
    assign rows[4] = 8'(SC_MATRIX_TX_ROW4_IN);
    assign rows[5] = 8'(SC_MATRIX_TX_ROW5_IN);
    assign rows[6] = 8'(SC_MATRIX_TX_ROW6_IN);
    assign rows[7] = 8'(SC_MATRIX_TX_ROW7_IN);
    assign half_end = half_cnt == 8'(CLKDIV - 1);
    assign k = 3'(idx - 4'd5);

    // Word 5 is loaded in the same cycle the snapshot is taken, so it uses the live row.
    always_comb begin
        case (idx)
            4'd0: word = 16'h0900;
            4'd1: word = {8'h0A, 4'h0, INTENSITY};
            4'd2: word = 16'h0B07;
            4'd3: word = 16'h0C01;
            4'd4: word = 16'h0F00;
            default: word = {4'h0, idx - 4'd4, (idx == 4'd5) ? rows[0] : snap[k]};
        endcase
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:       state_n = SC_MATRIX_TX_EN_IN ? LOAD_WORD : IDLE;
            LOAD_WORD:  state_n = SHIFT_LOW;
            SHIFT_LOW:  state_n = half_end ? SHIFT_HIGH : SHIFT_LOW;
            SHIFT_HIGH: state_n = !half_end ? SHIFT_HIGH : (bit_cnt == 4'd0 ? LATCH : SHIFT_LOW);
            LATCH:      state_n = half_end ? NEXT : LATCH;
            NEXT:       state_n = (idx != 4'd12 || SC_MATRIX_TX_EN_IN) ? LOAD_WORD : IDLE;
            default:    state_n = IDLE;
        endcase
    end

    always_ff @(posedge SC_MATRIX_TX_CLOCK_50) begin
        if (SC_MATRIX_TX_RESET) begin
            state <= IDLE;
            idx <= 4'd0;
            bit_cnt <= 4'd0;
            half_cnt <= 8'd0;
            sreg <= 16'd0;
            init_done <= 1'b0;
            snap <= '{default: 8'd0};
        end else begin
            state <= state_n;
            half_cnt <= (state_n == state && state != IDLE) ? half_cnt + 8'd1 : 8'd0;
            case (state)
                IDLE: idx <= init_done ? 4'd5 : 4'd0;
                LOAD_WORD: begin
                    sreg <= word;
                    bit_cnt <= 4'd15;
                    if (idx == 4'd5) snap <= rows;
                end
                SHIFT_HIGH: if (half_end && bit_cnt != 4'd0) begin
                    sreg <= sreg << 1;
                    bit_cnt <= bit_cnt - 4'd1;
                end
                NEXT: begin
                    idx <= (idx == 4'd12) ? 4'd5 : idx + 4'd1;
                    if (idx == 4'd12) init_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign SC_MATRIX_TX_DIN_OUT = (state == LOAD_WORD) ? word[15] : sreg[15];
    assign SC_MATRIX_TX_CLK_OUT = state == SHIFT_HIGH;
    assign SC_MATRIX_TX_LOAD_OUT = !(state inside {LOAD_WORD, SHIFT_LOW, SHIFT_HIGH});
    assign SC_MATRIX_TX_BUSY_OUT = state != IDLE;
    assign SC_MATRIX_TX_FRAME_DONE_OUT = state == NEXT && idx == 4'd12;
endmodule

// File: tb/tb_sc_matrix_tx.sv
// tb_sc_matrix_tx: scoreboard bench; a monitor decodes serial words from the
// default instance and checks them against queued expectations.
module tb_sc_matrix_tx;
    logic clk = 0, rst = 1, en0 = 0, en1 = 0;
    logic [7:0] row [8];
    logic din0, sck0, ld0, busy0, fd0;
    logic din1, sck1, ld1, busy1, fd1;
    int total = 0, bad = 0, cyc = 0;
    logic [15:0] exp_q [$];
    int fd_t [$];
    int fd_cnt = 0, fd_wide = 0, partials = 0, stab_err = 0, nb = 0, last_lrise = 0;
    logic pc0 = 0, pl0 = 1, pfd = 0, dhi = 0;
    logic [15:0] sh = 0;

    sc_matrix_tx u0 (
        .SC_MATRIX_TX_CLOCK_50(clk), .SC_MATRIX_TX_RESET(rst),
        .SC_MATRIX_TX_ROW0_IN(row[0]), .SC_MATRIX_TX_ROW1_IN(row[1]),
        .SC_MATRIX_TX_ROW2_IN(row[2]), .SC_MATRIX_TX_ROW3_IN(row[3]),
        .SC_MATRIX_TX_ROW4_IN(row[4]), .SC_MATRIX_TX_ROW5_IN(row[5]),
        .SC_MATRIX_TX_ROW6_IN(row[6]), .SC_MATRIX_TX_ROW7_IN(row[7]),
        .SC_MATRIX_TX_EN_IN(en0), .SC_MATRIX_TX_DIN_OUT(din0),
        .SC_MATRIX_TX_CLK_OUT(sck0), .SC_MATRIX_TX_LOAD_OUT(ld0),
        .SC_MATRIX_TX_BUSY_OUT(busy0), .SC_MATRIX_TX_FRAME_DONE_OUT(fd0)
    );

    sc_matrix_tx #(.CLKDIV(1)) u1 (
        .SC_MATRIX_TX_CLOCK_50(clk), .SC_MATRIX_TX_RESET(rst),
        .SC_MATRIX_TX_ROW0_IN(row[0]), .SC_MATRIX_TX_ROW1_IN(row[1]),
        .SC_MATRIX_TX_ROW2_IN(row[2]), .SC_MATRIX_TX_ROW3_IN(row[3]),
        .SC_MATRIX_TX_ROW4_IN(row[4]), .SC_MATRIX_TX_ROW5_IN(row[5]),
        .SC_MATRIX_TX_ROW6_IN(row[6]), .SC_MATRIX_TX_ROW7_IN(row[7]),
        .SC_MATRIX_TX_EN_IN(en1), .SC_MATRIX_TX_DIN_OUT(din1),
        .SC_MATRIX_TX_CLK_OUT(sck1), .SC_MATRIX_TX_LOAD_OUT(ld1),
        .SC_MATRIX_TX_BUSY_OUT(busy1), .SC_MATRIX_TX_FRAME_DONE_OUT(fd1)
    );

    always #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    task automatic push_rows(input logic [7:0] r3);
        logic [7:0] v [8] = '{8'h81, 8'h42, 8'h24, 8'h18, 8'h18, 8'h24, 8'h42, 8'h81};
        v[3] = r3;
        for (int i = 0; i < 8; i++) exp_q.push_back({4'h0, 4'(i + 1), v[i]});
    endtask

    task automatic push_init();
        exp_q.push_back(16'h0900);
        exp_q.push_back(16'h0A0F);
        exp_q.push_back(16'h0B07);
        exp_q.push_back(16'h0C01);
        exp_q.push_back(16'h0F00);
    endtask

    task automatic wait_fd(input int n, input int lim);
        for (int i = 0; i < lim && fd_cnt < n; i++) @(negedge clk);
        chk("frame_done count", fd_cnt, n);
    endtask

    // Monitor: decode words from u0 at each LOAD rise and check frame_done timing
    initial forever begin
        @(negedge clk);
        if (pc0 && sck0 && din0 !== dhi) stab_err++;
        if (!pc0 && sck0) begin
            sh = {sh[14:0], din0};
            nb++;
            dhi = din0;
        end
        if (!pl0 && ld0) begin
            last_lrise = cyc;
            if (nb != 16) partials++;
            else if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected word: got %h required none", sh);
            end else chk("serial word", sh, exp_q.pop_front());
        end
        if (pl0 && !ld0) nb = 0;
        if (fd0 && !pfd) begin
            fd_cnt++;
            fd_t.push_back(cyc);
            chk("frame_done after latch", cyc - last_lrise, 4);
        end
        if (fd0 && pfd) fd_wide++;
        pc0 = sck0;
        pl0 = ld0;
        pfd = fd0;
    end

    initial begin
        int t_ld, t_prev, k, tb;
        logic [15:0] w1;
        row = '{8'h81, 8'h42, 8'h24, 8'h18, 8'h18, 8'h24, 8'h42, 8'h81};
        repeat (3) @(negedge clk);
        chk("reset load", ld0, 1);
        chk("reset busy", busy0, 0);
        chk("reset clk", sck0, 0);
        chk("reset din", din0, 0);
        chk("reset frame_done", fd0, 0);
        chk("reset busy u1", busy1, 0);
        rst = 0;

        // CLKDIV=1 instance: 1-clock phases, 35-clock word, first word 0x0900
        en1 = 1;
        k = 0;
        while (ld1 !== 1'b0 && k < 20) begin @(negedge clk); k++; end
        t_ld = cyc;
        w1 = 0;
        t_prev = 0;
        for (int b = 0; b < 16; b++) begin
            k = 0;
            while (sck1 !== 1'b1 && k < 10) begin @(negedge clk); k++; end
            w1 = {w1[14:0], din1};
            if (b > 0) chk("clkdiv1 bit spacing", cyc - t_prev, 2);
            t_prev = cyc;
            @(negedge clk);
            chk("clkdiv1 high width", sck1, 0);
        end
        chk("clkdiv1 word", w1, 16'h0900);
        k = 0;
        while (ld1 !== 1'b1 && k < 10) begin @(negedge clk); k++; end
        while (ld1 !== 1'b0 && k < 20) begin @(negedge clk); k++; end
        chk("clkdiv1 word period", cyc - t_ld, 35);
        en1 = 0;
        repeat (13 * 35) @(negedge clk);
        chk("clkdiv1 idle after frame", busy1, 0);

        // Three back-to-back frames; ROW3 changes mid second frame
        push_init();
        push_rows(8'h18);
        push_rows(8'h18);
        push_rows(8'hFF);
        en0 = 1;
        wait_fd(1, 13 * 134 + 50);
        repeat (134 + 60) @(negedge clk);
        row[3] = 8'hFF;
        wait_fd(2, 8 * 134 + 50);
        repeat (300) @(negedge clk);
        en0 = 0;
        wait_fd(3, 8 * 134 + 50);
        @(negedge clk);
        chk("idle after en low", busy0, 0);
        if (fd_t.size() >= 3) begin
            chk("frame period 1-2", fd_t[1] - fd_t[0], 8 * 134);
            chk("frame period 2-3", fd_t[2] - fd_t[1], 8 * 134);
        end else chk("frame_done timestamps", fd_t.size(), 3);
        chk("queue drained", exp_q.size(), 0);

        // Reset during bit 7 of word 0x03xx, then init resent with EN dropped during init
        exp_q.push_back(16'h0181);
        exp_q.push_back(16'h0242);
        en0 = 1;
        k = 0;
        while (busy0 !== 1'b1 && k < 10) begin @(negedge clk); k++; end
        tb = cyc;
        repeat (2 * 134 + 70) @(negedge clk);
        rst = 1;
        @(negedge clk);
        chk("midword reset load", ld0, 1);
        chk("midword reset busy", busy0, 0);
        chk("midword reset clk", sck0, 0);
        chk("abandoned words", partials, 1);
        chk("queue before restart", exp_q.size(), 0);
        rst = 0;
        push_init();
        push_rows(8'hFF);
        repeat (200) @(negedge clk);
        en0 = 0;
        wait_fd(4, 13 * 134 + 100);
        repeat (20) @(negedge clk);
        chk("final idle", busy0, 0);
        chk("final queue drained", exp_q.size(), 0);
        chk("frame_done width", fd_wide, 0);
        chk("din stable while clk high", stab_err, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
